// File: rtl/am_error_accum.sv
// Error-metric accumulator for an approximate 8x8 unsigned multiplier.
// Samples {x, y, z_approx} arrive over a valid/ready handshake. The exact
// product is recomputed, and the error statistics are accumulated over
// N_SAMPLES samples through a three-stage pipeline:
//   S1 registers the operands.
//   S2 registers the signed error and its magnitude.
//   S3 updates the accumulators.
// Handshake: a sample transfers on any rising edge where in_valid and
// in_ready are both high. in_ready is registered and never looks at in_valid.
// The producer must hold x, y and z_approx stable while in_valid is high.
module am_error_accum #(
  parameter int N_SAMPLES = 65536,
  parameter int CNT_W     = 17,
  parameter int SUM_W     = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [7:0]              x,
  input  logic [7:0]              y,
  input  logic [15:0]             z_approx,
  output logic                    busy,
  output logic                    done,
  output logic [CNT_W-1:0]        sample_cnt,
  output logic [CNT_W-1:0]        err_cnt,
  output logic [SUM_W-1:0]        sum_abs_err,
  output logic signed [SUM_W:0]   sum_err,
  output logic [15:0]             max_abs_err,
  output logic                    sat,
  output logic [1:0]              fsm_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_SAMPLES - 1);

  state_t state_q, state_d;

  logic               accept;
  logic               clear;
  logic               s1_valid;
  logic [7:0]         s1_x, s1_y;
  logic [15:0]        s1_z;
  logic               s2_valid;
  logic signed [16:0] s2_err;
  logic [15:0]        s2_abs;

  logic [15:0]        exact_c;
  logic signed [16:0] err_c;
  logic [16:0]        neg_c;
  logic [15:0]        abs_c;
  logic [SUM_W+16:0]  abs_wide;
  logic [SUM_W+16:0]  err_wide;
  logic [SUM_W:0]     abs_sum_c;

  assign accept    = in_valid && in_ready;
  assign clear     = start && ((state_q == IDLE) || (state_q == DONE));
  assign busy      = (state_q == RUN) || (state_q == DRAIN);
  assign done      = (state_q == DONE);
  assign fsm_state = state_q;

  // S2 arithmetic: the exact product and the error against the approximate product.
  assign exact_c  = {8'd0, s1_x} * {8'd0, s1_y};
  assign err_c    = $signed({1'b0, exact_c}) - $signed({1'b0, s1_z});
  assign neg_c    = 17'(-err_c);
  assign abs_c    = err_c[16] ? neg_c[15:0] : err_c[15:0];

  // S3 arithmetic: widen the error terms and form the saturating sum with a carry bit.
  assign abs_wide  = {{SUM_W{1'b0}}, s2_abs};
  assign err_wide  = {{SUM_W{s2_err[16]}}, s2_err};
  assign abs_sum_c = {1'b0, sum_abs_err} + abs_wide[SUM_W:0];

  // Next-state logic: runs move RUN -> DRAIN -> DONE; start is only honoured in IDLE or DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (accept && (sample_cnt == LAST_IDX)) state_d = DRAIN;
      DRAIN:   if (!s1_valid && !s2_valid) state_d = DONE;
      DONE:    if (start) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  // State register. in_ready is registered and follows the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      in_ready <= 1'b0;
    end else begin
      state_q  <= state_d;
      in_ready <= (state_d == RUN);
    end
  end

  // S1 and S2 pipeline registers. Each stage has its own valid bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_x     <= '0;
      s1_y     <= '0;
      s1_z     <= '0;
      s2_valid <= 1'b0;
      s2_err   <= '0;
      s2_abs   <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_x <= x;
        s1_y <= y;
        s1_z <= z_approx;
      end
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_err <= err_c;
        s2_abs <= abs_c;
      end
    end
  end

  // Counters and S3 accumulators. They are cleared on a honoured start.
  // Only valid S2 entries update the accumulators, so bubbles leave them unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_cnt  <= '0;
      err_cnt     <= '0;
      sum_abs_err <= '0;
      sum_err     <= '0;
      max_abs_err <= '0;
      sat         <= 1'b0;
    end else if (clear) begin
      sample_cnt  <= '0;
      err_cnt     <= '0;
      sum_abs_err <= '0;
      sum_err     <= '0;
      max_abs_err <= '0;
      sat         <= 1'b0;
    end else begin
      if (accept) begin
        sample_cnt <= sample_cnt + 1'b1;
      end
      if (s2_valid) begin
        if (s2_err != '0) begin
          err_cnt <= err_cnt + 1'b1;
        end
        if (s2_abs > max_abs_err) begin
          max_abs_err <= s2_abs;
        end
        sum_err <= sum_err + $signed(err_wide[SUM_W:0]);
        if (abs_sum_c[SUM_W]) begin
          sum_abs_err <= '1;
          sat         <= 1'b1;
        end else begin
          sum_abs_err <= abs_sum_c[SUM_W-1:0];
        end
      end
    end
  end

endmodule
